// File: rtl/or_gate_pkg.sv
// rtl/or_gate_pkg.sv - shared index helpers for OR-reduction and priority-encoder blocks
// Purpose: width limits, index-width computation and a lowest-set-bit finder.
// Ports:   none (package).
package or_gate_pkg;

  localparam int MAX_WIDTH  = 64;
  localparam int MAX_STAGES = 3;

  // Index width for a WIDTH-bit vector; never narrower than one bit.
  function automatic int idx_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  // Lowest index holding a 1; returns 0 for an all-zero vector.
  function automatic logic [5:0] lowest_set_index(input logic [MAX_WIDTH-1:0] vec);
    logic [5:0] idx;
    idx = '0;
    for (int i = MAX_WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = 6'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/or_gate_sticky_n_if.sv
// rtl/or_gate_sticky_n_if.sv - request/status bundle of the sticky OR aggregator
// Purpose: groups raw request lines, enable/clear controls and aggregated status.
// Ports:   master drives inputs/enable_mask/clear/clear_mask and reads status;
//          slave (the aggregator) reads controls and drives pending/result/rise/first_idx.
interface or_gate_sticky_n_if #(
  parameter int WIDTH = 6
);
  import or_gate_pkg::*;

  localparam int IDX_W = idx_width(WIDTH);

  logic [WIDTH-1:0] inputs;
  logic [WIDTH-1:0] enable_mask;
  logic             clear;
  logic [WIDTH-1:0] clear_mask;
  logic [WIDTH-1:0] pending;
  logic             result;
  logic             rise;
  logic [IDX_W-1:0] first_idx;

  modport master (
    output inputs, enable_mask, clear, clear_mask,
    input  pending, result, rise, first_idx
  );

  modport slave (
    input  inputs, enable_mask, clear, clear_mask,
    output pending, result, rise, first_idx
  );

endinterface

// File: rtl/sync_bit_n.sv
// rtl/sync_bit_n.sv - single-bit STAGES-deep synchroniser, reset to 0
// Purpose: brings one asynchronous line into the clk domain.
// Ports:   clk, rst_n (async active-low), d (raw bit), q (synchronised bit).
module sync_bit_n #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  if (STAGES == 0) begin : g_bypass
    assign q = d;
  end else begin : g_chain
    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        chain <= '0;
      end else begin
        chain[0] <= d;
        for (int i = 1; i < STAGES; i++) begin
          chain[i] <= chain[i-1];
        end
      end
    end

    assign q = chain[STAGES-1];
  end

endmodule

// File: rtl/or_gate_sticky_n.sv
// rtl/or_gate_sticky_n.sv - N-input OR reduction with bubbles, synchronisers and sticky latches
// Purpose: aggregates status lines into one registered request and records the causing source.
// Ports:   sysclk, sys_rst_n (async active-low);
//          bus (slave): inputs, enable_mask, clear, clear_mask in;
//                       pending, result, rise, first_idx out (all registered).
module or_gate_sticky_n
  import or_gate_pkg::*;
#(
  parameter int          WIDTH        = 6,
  parameter logic [63:0] BUBBLES_MASK = 64'h1,
  parameter int          SYNC_STAGES  = 2,
  parameter logic [63:0] STICKY_MASK  = {64{1'b1}}
) (
  input  logic               sysclk,
  input  logic               sys_rst_n,
  or_gate_sticky_n_if.slave  bus
);

  localparam int IDX_W = idx_width(WIDTH);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("or_gate_sticky_n: WIDTH must be 1..64");
  end
  if (SYNC_STAGES < 0 || SYNC_STAGES > MAX_STAGES) begin : g_bad_stages
    $error("or_gate_sticky_n: SYNC_STAGES must be 0..3");
  end

  logic [WIDTH-1:0] real_in;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] pending_next;
  logic             result_next;
  logic             rise_next;

  logic [WIDTH-1:0] pending_q;
  logic             result_q;
  logic             rise_q;
  logic [IDX_W-1:0] first_idx_q;

  // Inverting ahead of the synchroniser means a freshly reset chain reads as
  // "no request" regardless of polarity.
  assign real_in = bus.inputs ^ BUBBLES_MASK[WIDTH-1:0];

  for (genvar i = 0; i < WIDTH; i++) begin : g_sync
    sync_bit_n #(
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .clk   (sysclk),
      .rst_n (sys_rst_n),
      .d     (real_in[i]),
      .q     (sync_in[i])
    );
  end

  always_comb begin
    pending_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!bus.enable_mask[i]) begin
        pending_next[i] = 1'b0;
      end else if (STICKY_MASK[i]) begin
        // Set wins over clear so an active source never shows a gap.
        if (sync_in[i])
          pending_next[i] = 1'b1;
        else if (bus.clear && bus.clear_mask[i])
          pending_next[i] = 1'b0;
        else
          pending_next[i] = pending_q[i];
      end else begin
        pending_next[i] = sync_in[i];
      end
    end
  end

  // Derived from pending_next so result and pending update on the same edge.
  assign result_next = |pending_next;
  assign rise_next   = result_next & ~result_q;

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pending_q   <= '0;
      result_q    <= 1'b0;
      rise_q      <= 1'b0;
      first_idx_q <= '0;
    end else begin
      pending_q <= pending_next;
      result_q  <= result_next;
      rise_q    <= rise_next;
      if (rise_next)
        first_idx_q <= IDX_W'(lowest_set_index(64'(pending_next)));
    end
  end

  assign bus.pending   = pending_q;
  assign bus.result    = result_q;
  assign bus.rise      = rise_q;
  assign bus.first_idx = first_idx_q;

endmodule

// File: tb/tb_or_gate_sticky_n.sv
// tb/tb_or_gate_sticky_n.sv - directed self-checking bench for or_gate_sticky_n
module tb_or_gate_sticky_n;

  logic sysclk;
  logic sys_rst_n;
  int   n_cmp;
  int   n_err;

  or_gate_sticky_n_if #(.WIDTH(6)) bus_a ();
  or_gate_sticky_n_if #(.WIDTH(6)) bus_b ();

  // dut_a: bubble on input 0, all sticky
  or_gate_sticky_n #(
    .WIDTH        (6),
    .BUBBLES_MASK (64'h1),
    .SYNC_STAGES  (2),
    .STICKY_MASK  ({64{1'b1}})
  ) dut_a (
    .sysclk    (sysclk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus_a.slave)
  );

  // dut_b: no bubbles, input 0 level-following
  or_gate_sticky_n #(
    .WIDTH        (6),
    .BUBBLES_MASK (64'h0),
    .SYNC_STAGES  (2),
    .STICKY_MASK  (64'h3E)
  ) dut_b (
    .sysclk    (sysclk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus_b.slave)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic test_reset();
    #20;
    n_cmp++; if (bus_a.pending !== 6'b0) begin n_err++; $display("FAIL reset_pending got %b want 000000", bus_a.pending); end
    n_cmp++; if (bus_a.result !== 1'b0) begin n_err++; $display("FAIL reset_result got %b want 0", bus_a.result); end
    n_cmp++; if (bus_a.rise !== 1'b0) begin n_err++; $display("FAIL reset_rise got %b want 0", bus_a.rise); end
    n_cmp++; if (bus_a.first_idx !== 3'd0) begin n_err++; $display("FAIL reset_first_idx got %0d want 0", bus_a.first_idx); end
    n_cmp++; if (bus_b.pending !== 6'b0) begin n_err++; $display("FAIL reset_pending_b got %b want 000000", bus_b.pending); end
  endtask

  task automatic test_bubble();
    tick();
    sys_rst_n = 1'b1;
    tick();
    tick();
    n_cmp++; if (bus_a.pending !== 6'b0) begin n_err++; $display("FAIL bubble_early got %b want 000000", bus_a.pending); end
    tick();
    n_cmp++; if (bus_a.pending !== 6'b000001) begin n_err++; $display("FAIL bubble_pending got %b want 000001", bus_a.pending); end
    n_cmp++; if (bus_a.result !== 1'b1) begin n_err++; $display("FAIL bubble_result got %b want 1", bus_a.result); end
    n_cmp++; if (bus_a.rise !== 1'b1) begin n_err++; $display("FAIL bubble_rise got %b want 1", bus_a.rise); end
    n_cmp++; if (bus_a.first_idx !== 3'd0) begin n_err++; $display("FAIL bubble_first_idx got %0d want 0", bus_a.first_idx); end
    tick();
    n_cmp++; if (bus_a.rise !== 1'b0) begin n_err++; $display("FAIL bubble_rise_once got %b want 0", bus_a.rise); end
    n_cmp++; if (bus_a.result !== 1'b1) begin n_err++; $display("FAIL bubble_result_hold got %b want 1", bus_a.result); end
    bus_a.enable_mask = 6'b111110;
    tick();
    n_cmp++; if (bus_a.pending !== 6'b0) begin n_err++; $display("FAIL bubble_disable got %b want 000000", bus_a.pending); end
    n_cmp++; if (bus_a.result !== 1'b0) begin n_err++; $display("FAIL bubble_disable_result got %b want 0", bus_a.result); end
  endtask

  task automatic test_sticky_capture();
    bus_a.inputs = 6'b010000;
    tick();
    bus_a.inputs = 6'b000000;
    tick();
    tick();
    n_cmp++; if (bus_a.pending !== 6'b010000) begin n_err++; $display("FAIL sticky_capture got %b want 010000", bus_a.pending); end
    n_cmp++; if (bus_a.rise !== 1'b1) begin n_err++; $display("FAIL sticky_rise got %b want 1", bus_a.rise); end
    n_cmp++; if (bus_a.first_idx !== 3'd4) begin n_err++; $display("FAIL sticky_first_idx got %0d want 4", bus_a.first_idx); end
    tick();
    tick();
    n_cmp++; if (bus_a.pending !== 6'b010000) begin n_err++; $display("FAIL sticky_hold got %b want 010000", bus_a.pending); end
    bus_a.clear      = 1'b1;
    bus_a.clear_mask = 6'b000000;
    tick();
    n_cmp++; if (bus_a.pending !== 6'b010000) begin n_err++; $display("FAIL clear_mask0 got %b want 010000", bus_a.pending); end
    bus_a.clear_mask = 6'b010000;
    tick();
    bus_a.clear = 1'b0;
    n_cmp++; if (bus_a.pending !== 6'b000000) begin n_err++; $display("FAIL clear_bit4 got %b want 000000", bus_a.pending); end
    n_cmp++; if (bus_a.result !== 1'b0) begin n_err++; $display("FAIL clear_result got %b want 0", bus_a.result); end
  endtask

  task automatic test_set_beats_clear();
    bus_a.inputs = 6'b000100;
    tick();
    tick();
    tick();
    n_cmp++; if (bus_a.pending !== 6'b000100) begin n_err++; $display("FAIL sbc_set got %b want 000100", bus_a.pending); end
    n_cmp++; if (bus_a.first_idx !== 3'd2) begin n_err++; $display("FAIL sbc_first_idx got %0d want 2", bus_a.first_idx); end
    tick();
    bus_a.clear      = 1'b1;
    bus_a.clear_mask = 6'b000100;
    tick();
    bus_a.clear = 1'b0;
    n_cmp++; if (bus_a.pending !== 6'b000100) begin n_err++; $display("FAIL sbc_pending got %b want 000100", bus_a.pending); end
    n_cmp++; if (bus_a.result !== 1'b1) begin n_err++; $display("FAIL sbc_result got %b want 1", bus_a.result); end
    n_cmp++; if (bus_a.rise !== 1'b0) begin n_err++; $display("FAIL sbc_rise got %b want 0", bus_a.rise); end
    tick();
    n_cmp++; if (bus_a.rise !== 1'b0) begin n_err++; $display("FAIL sbc_rise_after got %b want 0", bus_a.rise); end
    bus_a.inputs = 6'b000000;
    tick();
    tick();
    bus_a.clear = 1'b1;
    tick();
    bus_a.clear = 1'b0;
    n_cmp++; if (bus_a.pending !== 6'b000000) begin n_err++; $display("FAIL sbc_release got %b want 000000", bus_a.pending); end
  endtask

  task automatic test_first_source();
    bus_a.inputs = 6'b001010;
    tick();
    tick();
    tick();
    n_cmp++; if (bus_a.pending !== 6'b001010) begin n_err++; $display("FAIL first_pending got %b want 001010", bus_a.pending); end
    n_cmp++; if (bus_a.rise !== 1'b1) begin n_err++; $display("FAIL first_rise got %b want 1", bus_a.rise); end
    n_cmp++; if (bus_a.first_idx !== 3'd1) begin n_err++; $display("FAIL first_idx got %0d want 1", bus_a.first_idx); end
    bus_a.inputs = 6'b101010;
    tick();
    tick();
    tick();
    n_cmp++; if (bus_a.pending !== 6'b101010) begin n_err++; $display("FAIL first_late_pending got %b want 101010", bus_a.pending); end
    n_cmp++; if (bus_a.first_idx !== 3'd1) begin n_err++; $display("FAIL first_idx_hold got %0d want 1", bus_a.first_idx); end
    n_cmp++; if (bus_a.rise !== 1'b0) begin n_err++; $display("FAIL first_late_rise got %b want 0", bus_a.rise); end
  endtask

  task automatic test_enable_flush();
    bus_a.inputs = 6'b000000;
    tick();
    tick();
    bus_a.clear      = 1'b1;
    bus_a.clear_mask = 6'b000010;
    tick();
    bus_a.clear = 1'b0;
    n_cmp++; if (bus_a.pending !== 6'b101000) begin n_err++; $display("FAIL flush_pre got %b want 101000", bus_a.pending); end
    bus_a.enable_mask = 6'b011110;
    tick();
    n_cmp++; if (bus_a.pending !== 6'b001000) begin n_err++; $display("FAIL flush_bit5 got %b want 001000", bus_a.pending); end
    n_cmp++; if (bus_a.result !== 1'b1) begin n_err++; $display("FAIL flush_result got %b want 1", bus_a.result); end
  endtask

  task automatic test_reset_mid();
    sys_rst_n = 1'b0;
    #2;
    n_cmp++; if (bus_a.pending !== 6'b0) begin n_err++; $display("FAIL rstmid_pending got %b want 000000", bus_a.pending); end
    n_cmp++; if (bus_a.result !== 1'b0) begin n_err++; $display("FAIL rstmid_result got %b want 0", bus_a.result); end
    n_cmp++; if (bus_a.first_idx !== 3'd0) begin n_err++; $display("FAIL rstmid_first_idx got %0d want 0", bus_a.first_idx); end
    n_cmp++; if (bus_a.rise !== 1'b0) begin n_err++; $display("FAIL rstmid_rise got %b want 0", bus_a.rise); end
    bus_a.enable_mask = 6'b111110;
    tick();
    sys_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_non_sticky();
    logic [15:0] hist;
    logic        exp_p;
    logic        prev_p;
    int          rises;
    prev_p = 1'b0;
    rises  = 0;
    // clear held high throughout: must not disturb a level-following input
    bus_b.clear      = 1'b1;
    bus_b.clear_mask = 6'b111111;
    for (int k = 0; k < 16; k++) begin
      hist[k]         = ((k % 4) < 2);
      bus_b.inputs[0] = hist[k];
      tick();
      exp_p = (k >= 2) ? hist[k-2] : 1'b0;
      n_cmp++; if (bus_b.pending !== {5'b0, exp_p}) begin n_err++; $display("FAIL ns_pending k=%0d got %b want %b", k, bus_b.pending, {5'b0, exp_p}); end
      n_cmp++; if (bus_b.result !== exp_p) begin n_err++; $display("FAIL ns_result k=%0d got %b want %b", k, bus_b.result, exp_p); end
      n_cmp++; if (bus_b.rise !== (exp_p & ~prev_p)) begin n_err++; $display("FAIL ns_rise k=%0d got %b want %b", k, bus_b.rise, exp_p & ~prev_p); end
      if (bus_b.rise === 1'b1) rises++;
      prev_p = exp_p;
    end
    n_cmp++; if (rises !== 4) begin n_err++; $display("FAIL ns_rise_count got %0d want 4", rises); end
    bus_b.clear = 1'b0;
  endtask

  initial begin
    n_cmp             = 0;
    n_err             = 0;
    sys_rst_n         = 1'b0;
    bus_a.inputs      = '0;
    bus_a.enable_mask = 6'b111111;
    bus_a.clear       = 1'b0;
    bus_a.clear_mask  = '0;
    bus_b.inputs      = '0;
    bus_b.enable_mask = 6'b111111;
    bus_b.clear       = 1'b0;
    bus_b.clear_mask  = '0;

    test_reset();
    test_bubble();
    test_sticky_capture();
    test_set_beats_clear();
    test_first_source();
    test_enable_flush();
    test_reset_mid();
    test_non_sticky();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/or_gate_sticky_n.md
# or_gate_sticky_n

Parametrised N-input OR reduction with per-input inversion ("bubbles"), optional input synchronisers, and a per-input sticky latch with masked clear. It aggregates asynchronous or level status lines, such as interrupt, error or attention requests, into one registered, glitch-free request line. It also reports which source caused the request. It sits between raw status sources and sequencing logic that must not miss short pulses.

## Interface
Parameters:
- WIDTH, 6: number of inputs, 1..64.
- BUBBLES_MASK, 1: bit i = 1 inverts input i before any other processing. Bits at WIDTH and above are ignored.
- SYNC_STAGES, 2: synchroniser flops per input, 0..3. 0 means the inputs are already synchronous to sysclk.
- STICKY_MASK, all ones: bit i = 1 makes input i latching; bit i = 0 makes it level-following.

Ports (clock and reset first):
- sysclk, in, 1: the single clock; all flops are rising-edge.
- sys_rst_n, in, 1: reset, asynchronous and active-low.
- inputs, in, WIDTH: raw request lines.
- enable_mask, in, WIDTH: per-input enable, synchronous to sysclk.
- clear, in, 1: clear strobe, sampled each cycle.
- clear_mask, in, WIDTH: selects which sticky bits `clear` acts on.
- pending, out, WIDTH: registered per-input request state.
- result, out, 1: OR of `pending`, registered.
- rise, out, 1: one-cycle pulse when `result` goes 0→1.
- first_idx, out, IDX_W = max(1, $clog2(WIDTH)): index of the source captured at the last rise.

## Operation
- real[i] = inputs[i] ^ BUBBLES_MASK[i]. Inversion happens before synchronisation, so a reset-cleared synchroniser never presents a spurious request.
- sync[i] is real[i] delayed through SYNC_STAGES flops, all reset to 0. With SYNC_STAGES = 0, sync = real.
- pending[i] next state:
  - enable_mask[i] = 0 → 0. A disabled input is both blocked and flushed.
  - Sticky input: set when sync[i] = 1. Otherwise cleared when clear & clear_mask[i]. Otherwise held. Set has priority over clear in the same cycle.
  - Non-sticky input: pending[i] = sync[i]. `clear` has no effect.
- result next state = |pending_next. This keeps `result` aligned with `pending`.
- rise next state = result_next & ~result.
- first_idx: on a cycle where rise_next = 1, load the lowest index i with pending_next[i] = 1. Otherwise hold. It stays stable while `result` is 1 and after it falls, until the next rise.
- Out-of-range parameters (WIDTH = 0 or > 64, SYNC_STAGES > 3) are rejected with an elaboration-time error.

## Timing
- Reset (asynchronous assert, synchronous release): pending = 0, result = 0, rise = 0, first_idx = 0, all synchroniser flops = 0.
- Latency from an input edge to `pending` / `result`: SYNC_STAGES + 1 sysclk edges. `rise` is asserted in the same cycle `result` first reads 1.
- A sticky input asserted for one cycle at the synchroniser output is always captured.
- Clearing a sticky bit: `pending` drops one cycle after `clear`. If the source is still active it reasserts immediately, with no gap, and `rise` does not pulse.
- `result` falls only when every enabled pending bit is 0. `rise` never fires on consecutive cycles.
- If reset asserts mid-operation, all state clears immediately. Requests in flight inside the synchronisers are lost by design.

## Structure
- Shared package `or_gate_pkg`: function `lowest_set_index(vec)` and the IDX_W computation, reused by the future priority-encoder blocks.
- One sub-module: `sync_bit_n`, a single-bit SYNC_STAGES-deep synchroniser reset to 0. It is instantiated WIDTH times in a generate loop.

## Test plan
- Bubble check: WIDTH = 6, BUBBLES_MASK = 6'b000001, all inputs = 0, enable all ones, SYNC_STAGES = 2 → after reset release, pending = 6'b000001 on the 3rd edge, result = 1, rise pulses for 1 cycle, first_idx = 0.
- Sticky capture: one-cycle pulse on inputs[4] (mask 0) → pending[4] = 1 and held. `clear` with clear_mask = 6'b010000 → pending = 0 and result = 0 on the next edge. `clear` with clear_mask = 0 → no change.
- Set beats clear: inputs[2] held high while `clear` is pulsed with mask bit 2 set → pending[2] stays 1, result stays 1, rise does not pulse.
- Non-sticky mix: STICKY_MASK = 6'b111110, inputs[0] toggles with period 4 → pending[0] and result follow it with 3-cycle latency, and rise pulses once per period.
- First source: inputs[3] and inputs[1] rise in the same cycle → first_idx = 1. Then inputs[5] rises while result is still 1 → first_idx stays 1.
- Enable flush and reset: pending = 6'b101000, enable_mask[5] dropped → pending = 6'b001000 next cycle. Asserting sys_rst_n low mid-stream → all outputs 0 without waiting for a clock edge.
